// File: rtl/fm_pkg.sv
// Shared definitions for the fp32 multiplier issuer: widths, window length,
// FSM state encoding and the canonical quiet NaN.
package fm_pkg;
  localparam int FP_W = 32;
  localparam int MUL_LAT = 8;
  localparam logic [FP_W-1:0] FP_QNAN = 32'hFFC00000;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;
endpackage

// File: rtl/fm_res_fifo.sv
// In-order result FIFO. Output data comes straight from the storage registers,
// and the occupancy count is exported so the issuer can reserve credits.
module fm_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Credits are reserved at issue, so neither of these can ever fire.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == (AW+1)'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count == '0)));
endmodule

// File: rtl/fm_issuer.sv
// Initiator for the fp32 multiplier: issues 8-cycle enable windows, captures
// each product in its single valid cycle and queues results in order.
//   state | meaning
//   IDLE  | mul_v low, waiting for an operand pair with a free result credit
//   RUN   | mul_v high, phase counts the window; reload possible at last phase
module fm_issuer
  import fm_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int MUL_LAT   = fm_pkg::MUL_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            in_last,
  output logic            mul_v,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  input  logic [31:0]     mul_z,
  input  logic            mul_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_z,
  output logic            out_last,
  output logic            err
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [2:0] PH_LAST = 3'(MUL_LAT - 1);

  state_t        state, state_nx;
  logic [2:0]    phase;
  logic          last_q, last_q_prev;
  logic          cap_pending;
  logic          en;
  logic          accept;
  logic          win_end;
  logic          credit_ok;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   reserved;
  logic [FP_W:0] fifo_data;

  // The window in flight holds a credit too, so its result always has a slot.
  assign reserved  = {1'b0, fifo_count} + (CW+1)'(cap_pending) + (CW+1)'(state == RUN);
  assign credit_ok = reserved < (CW+1)'(OUT_DEPTH);
  assign win_end   = (state == RUN) && (phase == PH_LAST);

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mul_v    = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = en && credit_ok;
        accept   = in_valid && in_ready;
        if (accept) state_nx = RUN;
      end
      RUN: begin
        mul_v    = 1'b1;
        in_ready = en && credit_ok && (phase == PH_LAST);
        accept   = in_valid && in_ready;
        if (phase == PH_LAST && !accept) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      last_q      <= 1'b0;
      last_q_prev <= 1'b0;
      cap_pending <= 1'b0;
      err         <= 1'b0;
      en          <= 1'b0;
    end else begin
      en          <= 1'b1;
      state       <= state_nx;
      cap_pending <= win_end;
      if (state == RUN) phase <= phase + 3'd1;
      if (accept) begin
        mul_a  <= in_a;
        mul_b  <= in_b;
        last_q <= in_last;
      end
      // Snapshot before a same-edge reload overwrites last_q.
      if (win_end) last_q_prev <= last_q;
      if (cap_pending && !mul_valid) err <= 1'b1;
    end
  end

  fm_res_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (FP_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_pending),
    .push_data ({mul_z, last_q_prev}),
    .pop       (out_valid && out_ready),
    .out_valid (out_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign out_z    = fifo_data[FP_W:1];
  assign out_last = fifo_data[0];
endmodule

// File: tb/tb_fm_issuer.sv
// Self-checking bench for fm_issuer with a behavioural multiplier model and a
// result scoreboard filled at operand accept and drained at the output stream.
module tb_fm_issuer;
  import fm_pkg::*;

  typedef struct packed {
    logic [31:0] z;
    logic        last;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_a, in_b;
  logic        mul_v;
  logic [31:0] mul_a, mul_b, mul_z;
  logic        mul_valid;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_z;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run = 0;
  int   last_run = 0;
  int   accepts = 0;
  int   acc_cyc = 0;
  int   accepts0;
  logic withhold;
  logic [2:0] m_cnt;
  res_t sb[$];
  int   pop_cyc[$];

  fm_issuer #(.OUT_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mul_v     (mul_v),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .mul_valid (mul_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Products for the operand pairs this bench uses.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h7F800000 && b == 32'h00000000) return FP_QNAN;
    if (a == 32'h80000000 && b == 32'h3F800000) return 32'h80000000;
    if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000) return b;
    return 32'hDEADBEEF;
  endfunction

  // Multiplier model: 3-bit counter runs while v is high; the product is valid
  // for the one cycle after count 7; valid is held stale while v is low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= '0;
      mul_valid <= 1'b0;
      mul_z     <= '0;
    end else if (mul_v) begin
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd7) begin
        mul_z     <= fp_mul(mul_a, mul_b);
        mul_valid <= !withhold;
      end else begin
        mul_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (mul_v) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (in_valid && in_ready) accepts++;
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          res_t e;
          e = sb.pop_front();
          check("out_z", out_z, e.z);
          check("out_last", out_last, e.last);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                      input logic [31:0] exp_z);
    int n = 0;
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      sb.push_back(res_t'{z: exp_z, last: last});
      acc_cyc = cyc + 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; withhold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mul_v", mul_v, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op: window length and latency
    pop_cyc.delete();
    send(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000);
    repeat (14) @(posedge clk); #1;
    check("single_mul_v_len", last_run, 8);
    check("single_count", pop_cyc.size(), 1);
    if (pop_cyc.size() == 1) check("single_latency", pop_cyc[0] - acc_cyc + 1, 10);

    // Back-to-back: continuous window, results every 8 cycles
    pop_cyc.delete();
    for (int i = 0; i < 5; i++)
      send(32'h3F800000, 32'h41000000 + i, (i == 4), 32'h41000000 + i);
    repeat (20) @(posedge clk); #1;
    check("b2b_mul_v_len", last_run, 40);
    check("b2b_count", pop_cyc.size(), 5);
    if (pop_cyc.size() == 5)
      for (int i = 1; i < 5; i++) check("b2b_spacing", pop_cyc[i] - pop_cyc[i-1], 8);

    // Backpressure: only four windows fit while the output is stalled
    out_ready = 1'b0;
    accepts0 = accepts;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'h3F800000, 32'h42000000 + i, (i == 5), 32'h42000000 + i);
      end
      begin
        repeat (80) @(posedge clk); #1;
        check("bp_windows", accepts - accepts0, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    repeat (60) @(posedge clk); #1;
    check("bp_total_accepts", accepts - accepts0, 6);
    check("bp_sb_drained", sb.size(), 0);

    // Special values
    send(32'h7F800000, 32'h00000000, 1'b0, FP_QNAN);
    send(32'h80000000, 32'h3F800000, 1'b1, 32'h80000000);
    repeat (15) @(posedge clk); #1;
    check("special_sb_drained", sb.size(), 0);

    // Protocol error: withheld valid still pushes, err is sticky
    check("err_before", err, 0);
    withhold = 1'b1;
    send(32'h3F800000, 32'h12345678, 1'b0, 32'h12345678);
    repeat (12) @(posedge clk); #1;
    withhold = 1'b0;
    check("err_set", err, 1);
    send(32'h3F800000, 32'h23456789, 1'b1, 32'h23456789);
    repeat (12) @(posedge clk); #1;
    check("err_sticky", err, 1);
    check("err_sb_drained", sb.size(), 0);

    // Reset in the middle of a window
    send(32'h3F800000, 32'h11111111, 1'b0, 32'h11111111);
    repeat (4) @(posedge clk); #3;
    check("pre_rst_phase", dut.phase, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_mul_v", mul_v, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_mul_a", mul_a, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_z", out_z, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_err", err, 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pop_cyc.delete();
    send(32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000);
    repeat (14) @(posedge clk); #1;
    check("postrst_mul_v_len", last_run, 8);
    check("postrst_count", pop_cyc.size(), 1);
    if (pop_cyc.size() == 1) check("postrst_latency", pop_cyc[0] - acc_cyc + 1, 10);
    check("postrst_sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fm_issuer.md
# fm_issuer

Initiator side of the fp32 multiplier handshake (`v`/`valid`). Accepts operand pairs on a ready/valid stream and drives the multiplier's 8-cycle enable window. Captures each product in the single cycle it is valid and returns results in order on a ready/valid output stream backed by a small FIFO. Sits between the fully-connected layer's operand fetch and its accumulator.

## Interface
- `OUT_DEPTH`, 4: result FIFO entries (power of two, ≥2)
- `MUL_LAT`, 8: v-high cycles per multiply; fixed by the multiplier's 3-bit counter
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low; the multiplier shares this reset
- `in_valid` in 1: operand pair offered
- `in_ready` out 1: pair accepted when `in_valid && in_ready`
- `in_a`, `in_b` in 32: fp32 operands
- `in_last` in 1: last pair of a vector, forwarded with its result
- `mul_v` out 1: multiplier enable
- `mul_a`, `mul_b` out 32: operands to the multiplier, held for the whole window
- `mul_z` in 32: multiplier result
- `mul_valid` in 1: multiplier result flag
- `out_valid` out 1, `out_ready` in 1: result stream handshake
- `out_z` out 32, `out_last` out 1: product and forwarded last flag
- `err` out 1: sticky protocol error

## Operation
- Reset values: `in_ready`=0, `mul_v`=0, `mul_a`=`mul_b`=0, `out_valid`=0, `out_z`=0, `out_last`=0, `err`=0. Internal `phase`=0, `cap_pending`=0, FIFO empty, state IDLE.
- `phase` (3 bits) mirrors the multiplier counter. It increments only while `mul_v`=1 and wraps 7→0. `mul_v` changes only at `phase`=0, so the issuer and multiplier never lose alignment.
- Credit rule: a window may start only if FIFO occupancy + `cap_pending` < `OUT_DEPTH`.
- `in_ready` = (state IDLE, or RUN with `phase`=7) AND credit rule holds, counting the result about to be pushed.
- States:
  - IDLE: `mul_v`=0. On accept, latch a/b/last into `mul_a`/`mul_b`/`last_q` and go to RUN with `phase`=0.
  - RUN: `mul_v`=1. At `phase`=7, set `cap_pending`=1 for the following cycle.
    - If a new pair is accepted at `phase`=7, reload operands on that edge and stay in RUN.
    - Otherwise go to IDLE.
- Capture cycle (`cap_pending`=1):
  - Push {`mul_z`, `last_q_prev`} into the FIFO; clear `cap_pending`.
  - If `mul_valid`=0, still push and set `err`=1. `err` stays set until reset.
  - The previous window's last flag is kept in a second register so a back-to-back reload cannot corrupt it.
- `mul_valid` is ignored outside capture cycles. While `mul_v`=0 the multiplier holds `valid` high stale.
- FIFO: standard ready/valid, in-order. Simultaneous push and pop when full cannot occur, because credits are reserved at issue.
- Overflow and underflow are impossible by construction. An assertion checks both.

## Timing
- Accept at edge E0: `mul_v`=1 in cycles E0+1 through E0+8. Capture happens in cycle E0+9. The result is visible on `out_valid` from cycle E0+10.
- First-result latency from accept to `out_valid` is 10 cycles.
- Sustained throughput is one product per 8 cycles, with `mul_v` held continuously.
- `out_valid` holds with stable `out_z`/`out_last` until `out_ready`.
- Asynchronous reset mid-window drops the in-flight op and the FIFO contents. Both blocks restart with counter/`phase`=0.

## Structure
- Shared package `fm_pkg`:
  - `FP_W`=32
  - `MUL_LAT`=8
  - state enum {IDLE, RUN}
  - `FP_QNAN`=32'hFFC00000 for bench checks
- Sub-module `fm_res_fifo`: parameterised depth/width, registered output, occupancy count output used for credits.

## Test plan
- Single op: a=0x40000000, b=0x40400000 → `mul_v` high for exactly 8 cycles; `out_z`=0x40C00000 with `out_last`=1 at accept+10.
- Back-to-back: 5 pairs offered continuously → `mul_v` never drops for 40 cycles; results arrive in order, spaced 8 cycles apart.
- Backpressure: `out_ready`=0, 6 pairs offered with `OUT_DEPTH`=4 → exactly 4 windows issued, then `in_ready`=0. Releasing `out_ready` resumes issue; no result is lost or duplicated.
- Special values: 0x7F800000 × 0x00000000 → `out_z`=0xFFC00000; 0x80000000 × 0x3F800000 → `out_z`=0x80000000.
- Protocol error: bench model withholds `mul_valid` in one capture cycle → result still pushed, `err`=1 and sticky.
- Reset at phase 4 → all outputs at reset values immediately. A subsequent op 1.5×2.0 returns 0x40400000 with correct alignment.
